// File: rtl/cpu_pkg.sv
// Shared definitions for the decoder and the execute datapath:
// data/address widths, ALU opcodes and the halt latch state type.
package cpu_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 4;

  localparam logic [3:0] ALU_PASS_A = 4'b0000;
  localparam logic [3:0] ALU_PASS_B = 4'b0001;
  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_NEG    = 4'b0011;
  localparam logic [3:0] ALU_AND    = 4'b0100;
  localparam logic [3:0] ALU_OR     = 4'b0101;
  localparam logic [3:0] ALU_SHL    = 4'b0110;
  localparam logic [3:0] ALU_SHR    = 4'b0111;
  localparam logic [3:0] ALU_EQ     = 4'b1000;
  localparam logic [3:0] ALU_GT     = 4'b1001;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } halt_state_t;

endpackage

// File: rtl/alu_unit.sv
// Purely combinational ALU; unsigned arithmetic truncated to DATA_W.
// carry reports the ADD carry-out or the last bit shifted out by SHL/SHR.
module alu_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic [3:0]        aluOpCode,
  output logic [DATA_W-1:0] result,
  output logic              carry
);
  import cpu_pkg::*;

  logic [3:0]      shamt;
  logic [DATA_W:0] sum;
  logic [DATA_W:0] shl_ext;
  logic [DATA_W:0] shr_ext;

  // One guard bit on each shift catches the last bit shifted out; amounts
  // past the width naturally flush both result and carry to zero.
  assign shamt   = opB[3:0];
  assign sum     = {1'b0, opA} + {1'b0, opB};
  assign shl_ext = {1'b0, opA} << shamt;
  assign shr_ext = {opA, 1'b0} >> shamt;

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (aluOpCode)
      ALU_PASS_A: result = opA;
      ALU_PASS_B: result = opB;
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
      end
      ALU_NEG:    result = '0 - opB;
      ALU_AND:    result = opA & opB;
      ALU_OR:     result = opA | opB;
      ALU_SHL: begin
        result = shl_ext[DATA_W-1:0];
        carry  = shl_ext[DATA_W];
      end
      ALU_SHR: begin
        result = shr_ext[DATA_W:1];
        carry  = shr_ext[0];
      end
      ALU_EQ:     result = {{(DATA_W-1){1'b0}}, (opA == opB)};
      ALU_GT:     result = {{(DATA_W-1){1'b0}}, (opA > opB)};
      default: begin
        result = '0;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_datapath.sv
// Execute stage: register file, ALU, write-back and sticky halt latch.
// Define CPU_DATAPATH_FLAGS_EN to add zeroFlag/carryFlag outputs.
module cpu_datapath #(
  parameter int DATA_W    = cpu_pkg::DATA_W,
  parameter int REG_COUNT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] destAddress,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] aAddress,
  input  logic [cpu_pkg::REG_ADDR_W-1:0] bAddress,
  input  logic                          muxASelect,
  input  logic                          muxBSelect,
  input  logic [3:0]                    aluOpCode,
  input  logic                          writeSourceSelect,
  input  logic                          writeEnable,
  input  logic                          conditionalWrite,
  input  logic                          haltRequest,
  input  logic                          haltCondition,
  input  logic [DATA_W-1:0]             selectedInputData,
  output logic                          halt,
  output logic [DATA_W-1:0]             outputData,
  output logic [DATA_W-1:0]             aluResult
`ifdef CPU_DATAPATH_FLAGS_EN
  ,
  output logic                          zeroFlag,
  output logic                          carryFlag
`endif
);
  import cpu_pkg::*;

  halt_state_t       state;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] wdata;
  logic              alu_carry;
  logic              cond_true;
  logic              commit;
  logic              halt_now;

  assign op_a      = muxASelect ? selectedInputData : regs[aAddress];
  assign op_b      = muxBSelect ? selectedInputData : regs[bAddress];
  assign cond_true = (regs[aAddress] != '0);
  assign wdata     = writeSourceSelect ? selectedInputData : aluResult;
  assign commit    = writeEnable && (state == RUN) && (!conditionalWrite || cond_true);
  assign halt_now  = haltRequest || (haltCondition && cond_true);

  alu_unit #(.DATA_W(DATA_W)) u_alu (
    .opA       (op_a),
    .opB       (op_b),
    .aluOpCode (aluOpCode),
    .result    (aluResult),
    .carry     (alu_carry)
  );

  // Reads see the pre-edge contents, so same-cycle read/write returns the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
      outputData <= '0;
    end else if (commit) begin
      regs[destAddress] <= wdata;
      outputData        <= wdata;
    end
  end

  // Halt is sticky: only reset returns the datapath to RUN.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_now) begin
            state <= HALTED;
            halt  <= 1'b1;
          end
        end
        HALTED: halt <= 1'b1;
        default: begin
          state <= RUN;
          halt  <= 1'b0;
        end
      endcase
    end
  end

`ifdef CPU_DATAPATH_FLAGS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      zeroFlag  <= 1'b0;
      carryFlag <= 1'b0;
    end else if (commit && !writeSourceSelect) begin
      zeroFlag  <= (wdata == '0);
      carryFlag <= alu_carry;
    end
  end
`else
  logic unused_alu_carry;
  assign unused_alu_carry = alu_carry;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Scoreboard bench for cpu_datapath: stimulus queues expected outputs tagged
// with the cycle they are due, a negedge monitor pops and compares them.
module tb_cpu_datapath;
  import cpu_pkg::*;

  localparam int SEL_ALU   = 0;
  localparam int SEL_OUT   = 1;
  localparam int SEL_HALT  = 2;
  localparam int SEL_ZERO  = 3;
  localparam int SEL_CARRY = 4;

  typedef struct packed {
    logic [3:0] dest;
    logic [3:0] a;
    logic [3:0] b;
    logic       mA;
    logic       mB;
    logic [3:0] op;
    logic       ws;
    logic       we;
    logic       cw;
    logic       hr;
    logic       hc;
    logic [7:0] data;
  } instr_t;

  typedef struct {
    string      name;
    int         cyc;
    int         sel;
    logic [7:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] destAddress, aAddress, bAddress, aluOpCode;
  logic       muxASelect, muxBSelect, writeSourceSelect, writeEnable;
  logic       conditionalWrite, haltRequest, haltCondition;
  logic [7:0] selectedInputData;
  logic       halt;
  logic [7:0] outputData, aluResult;
`ifdef CPU_DATAPATH_FLAGS_EN
  logic       zeroFlag, carryFlag;
`endif

  exp_t       sb[$];
  int         cycle  = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       mon_e;
  logic [7:0] mon_act;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  cpu_datapath dut (
    .clk               (clk),
    .rst               (rst),
    .destAddress       (destAddress),
    .aAddress          (aAddress),
    .bAddress          (bAddress),
    .muxASelect        (muxASelect),
    .muxBSelect        (muxBSelect),
    .aluOpCode         (aluOpCode),
    .writeSourceSelect (writeSourceSelect),
    .writeEnable       (writeEnable),
    .conditionalWrite  (conditionalWrite),
    .haltRequest       (haltRequest),
    .haltCondition     (haltCondition),
    .selectedInputData (selectedInputData),
    .halt              (halt),
    .outputData        (outputData),
    .aluResult         (aluResult)
`ifdef CPU_DATAPATH_FLAGS_EN
    ,
    .zeroFlag          (zeroFlag),
    .carryFlag         (carryFlag)
`endif
  );

  function automatic instr_t nop();
    return '0;
  endfunction

  function automatic logic [7:0] sample(input int sel);
    case (sel)
      SEL_ALU:   return aluResult;
      SEL_OUT:   return outputData;
      SEL_HALT:  return {7'b0, halt};
`ifdef CPU_DATAPATH_FLAGS_EN
      SEL_ZERO:  return {7'b0, zeroFlag};
      SEL_CARRY: return {7'b0, carryFlag};
`endif
      default:   return 8'hxx;
    endcase
  endfunction

  // Monitor: every expectation due by this cycle is compared mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle) begin
      mon_e   = sb.pop_front();
      mon_act = sample(mon_e.sel);
      checks++;
      if (mon_act !== mon_e.val) begin
        errors++;
        $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h (cycle %0d)",
                 mon_e.name, mon_act, mon_e.val, cycle);
      end
    end
  end

  task automatic apply_stimulus(input instr_t i);
    destAddress       = i.dest;
    aAddress          = i.a;
    bAddress          = i.b;
    muxASelect        = i.mA;
    muxBSelect        = i.mB;
    aluOpCode         = i.op;
    writeSourceSelect = i.ws;
    writeEnable       = i.we;
    conditionalWrite  = i.cw;
    haltRequest       = i.hr;
    haltCondition     = i.hc;
    selectedInputData = i.data;
  endtask

  task automatic drive(input instr_t i);
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply_stimulus(i);
  endtask

  task automatic expect_out(input string name, input int sel, input logic [7:0] val, input int dly);
    exp_t e;
    e.name = name;
    e.cyc  = cycle + dly;
    e.sel  = sel;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic expect_flags(input string name, input logic z, input logic c, input int dly);
    expect_out({name, "_zero"}, SEL_ZERO, {7'b0, z}, dly);
    expect_out({name, "_carry"}, SEL_CARRY, {7'b0, c}, dly);
  endtask

  task automatic write_imm(input logic [3:0] dest, input logic [7:0] val,
                           input logic [7:0] exp_out, input string name);
    instr_t i;
    i      = nop();
    i.dest = dest;
    i.ws   = 1'b1;
    i.we   = 1'b1;
    i.data = val;
    drive(i);
    expect_out(name, SEL_OUT, exp_out, 1);
  endtask

  task automatic read_reg(input logic [3:0] addr, input logic [7:0] val, input string name);
    instr_t i;
    i    = nop();
    i.a  = addr;
    i.op = ALU_PASS_A;
    drive(i);
    expect_out(name, SEL_ALU, val, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t i;
    rst = 1'b0;
    apply_stimulus(nop());
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    expect_out("reset_halt", SEL_HALT, 8'h00, 0);
    expect_out("reset_out", SEL_OUT, 8'h00, 0);
`ifdef CPU_DATAPATH_FLAGS_EN
    expect_flags("reset", 1'b0, 1'b0, 0);
`endif

    read_reg(4'd3, 8'h00, "reset_r3");
    write_imm(4'd3, 8'h5A, 8'h5A, "load_out");
    read_reg(4'd3, 8'h5A, "load_r3");
    expect_out("load_halt", SEL_HALT, 8'h00, 0);

    // 0xF0 + 0x20 wraps to 0x10 with carry out
    write_imm(4'd1, 8'hF0, 8'hF0, "load_r1_out");
    write_imm(4'd2, 8'h20, 8'h20, "load_r2_out");
    i = nop(); i.dest = 4'd4; i.a = 4'd1; i.b = 4'd2; i.op = ALU_ADD; i.we = 1'b1;
    drive(i);
    expect_out("add_alu", SEL_ALU, 8'h10, 0);
    expect_out("add_out", SEL_OUT, 8'h10, 1);
`ifdef CPU_DATAPATH_FLAGS_EN
    expect_flags("add", 1'b0, 1'b1, 1);
`endif
    read_reg(4'd4, 8'h10, "add_r4");

    // Same-cycle read of the register being written sees the old value
    i = nop(); i.dest = 4'd4; i.a = 4'd4; i.ws = 1'b1; i.we = 1'b1; i.data = 8'h77;
    drive(i);
    expect_out("nobypass_alu", SEL_ALU, 8'h10, 0);
    expect_out("nobypass_out", SEL_OUT, 8'h77, 1);
    read_reg(4'd4, 8'h77, "after_write_r4");

    i = nop(); i.mA = 1'b1; i.data = 8'h3C; i.b = 4'd2; i.op = ALU_AND;
    drive(i);
    expect_out("and_alu", SEL_ALU, 8'h20, 0);
    i.op = ALU_OR;
    drive(i);
    expect_out("or_alu", SEL_ALU, 8'h3C, 0);
    i = nop(); i.mB = 1'b1; i.data = 8'h01; i.op = ALU_NEG;
    drive(i);
    expect_out("neg_alu", SEL_ALU, 8'hFF, 0);
    i.op = ALU_PASS_B;
    drive(i);
    expect_out("passb_alu", SEL_ALU, 8'h01, 0);
    i = nop(); i.mA = 1'b1; i.data = 8'hFF; i.op = 4'hC;
    drive(i);
    expect_out("badop_alu", SEL_ALU, 8'h00, 0);

    write_imm(4'd5, 8'h00, 8'h00, "load_r5_zero_out");
    i = nop(); i.dest = 4'd7; i.a = 4'd5; i.ws = 1'b1; i.we = 1'b1; i.cw = 1'b1; i.data = 8'hAB;
    drive(i);
    expect_out("cond_skip_out", SEL_OUT, 8'h00, 1);
    read_reg(4'd7, 8'h00, "cond_skip_r7");
    write_imm(4'd5, 8'h01, 8'h01, "load_r5_one_out");
    drive(i);
    expect_out("cond_take_out", SEL_OUT, 8'hAB, 1);
    read_reg(4'd7, 8'hAB, "cond_take_r7");

    // Shift by r5 (=1), r9 (=9) and compares
    i = nop(); i.dest = 4'd8; i.mA = 1'b1; i.data = 8'h81; i.b = 4'd5; i.op = ALU_SHL; i.we = 1'b1;
    drive(i);
    expect_out("shl1_alu", SEL_ALU, 8'h02, 0);
    expect_out("shl1_out", SEL_OUT, 8'h02, 1);
`ifdef CPU_DATAPATH_FLAGS_EN
    expect_flags("shl1", 1'b0, 1'b1, 1);
`endif
    write_imm(4'd9, 8'h09, 8'h09, "load_r9_out");
    i.b = 4'd9; i.op = ALU_SHR;
    drive(i);
    expect_out("shr9_alu", SEL_ALU, 8'h00, 0);
    expect_out("shr9_out", SEL_OUT, 8'h00, 1);
`ifdef CPU_DATAPATH_FLAGS_EN
    expect_flags("shr9", 1'b1, 1'b0, 1);
`endif
    i = nop(); i.mA = 1'b1; i.data = 8'h81; i.b = 4'd5; i.op = ALU_SHR;
    drive(i);
    expect_out("shr1_alu", SEL_ALU, 8'h40, 0);
    i = nop(); i.dest = 4'd10; i.mA = 1'b1; i.mB = 1'b1; i.data = 8'h33; i.op = ALU_EQ; i.we = 1'b1;
    drive(i);
    expect_out("eq_alu", SEL_ALU, 8'h01, 0);
    expect_out("eq_out", SEL_OUT, 8'h01, 1);
`ifdef CPU_DATAPATH_FLAGS_EN
    expect_flags("eq", 1'b0, 1'b0, 1);
`endif
    write_imm(4'd11, 8'h80, 8'h80, "load_r11_out");
    i = nop(); i.mA = 1'b1; i.data = 8'h01; i.b = 4'd11; i.op = ALU_GT;
    drive(i);
    expect_out("gt_false_alu", SEL_ALU, 8'h00, 0);
    i.data = 8'h81;
    drive(i);
    expect_out("gt_true_alu", SEL_ALU, 8'h01, 0);

    i = nop(); i.a = 4'd6; i.hc = 1'b1;
    drive(i);
    expect_out("halt_cond_zero", SEL_HALT, 8'h00, 1);
    write_imm(4'd6, 8'h07, 8'h07, "load_r6_out");
    // Halting instruction still commits its own write
    i = nop(); i.dest = 4'd12; i.a = 4'd6; i.hc = 1'b1; i.ws = 1'b1; i.we = 1'b1; i.data = 8'h3C;
    drive(i);
    expect_out("halt_set", SEL_HALT, 8'h01, 1);
    expect_out("halt_write_out", SEL_OUT, 8'h3C, 1);
    write_imm(4'd12, 8'h99, 8'h3C, "halted_write_out");
    expect_out("halt_sticky", SEL_HALT, 8'h01, 0);
    read_reg(4'd12, 8'h3C, "halted_r12");

    // Reset while halted, with a write presented in the same cycle
    @(posedge clk);
    #1;
    rst = 1'b0;
    i = nop(); i.dest = 4'd12; i.ws = 1'b1; i.we = 1'b1; i.data = 8'hEE;
    apply_stimulus(i);
    expect_out("rst_halt", SEL_HALT, 8'h00, 1);
    expect_out("rst_out", SEL_OUT, 8'h00, 1);
`ifdef CPU_DATAPATH_FLAGS_EN
    expect_flags("rst", 1'b0, 1'b0, 1);
`endif
    read_reg(4'd12, 8'h00, "rst_r12");
    read_reg(4'd6, 8'h00, "rst_r6");
    read_reg(4'd3, 8'h00, "rst_r3");

    repeat (3) drive(nop());
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Execute stage directly downstream of the instruction decoder.
- Holds the 16-entry register file and the ALU, applies the decoder's control word, and writes results back.
- Owns the sticky halt latch that freezes the program counter in the decoder.
- Exposes the last written value as the design's display output.

Parameters:
- DATA_W, 8, register/ALU data width.
- REG_COUNT, 16, number of registers; addressed by 4-bit fields.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-low (sampled on clk rising edge; low = reset).
- destAddress  input  4  write-back register index.
- aAddress  input  4  register A read index (also the condition register).
- bAddress  input  4  register B read index.
- muxASelect  input  1  1 = operand A from selectedInputData, 0 = regfile[aAddress].
- muxBSelect  input  1  1 = operand B from selectedInputData, 0 = regfile[bAddress].
- aluOpCode  input  4  ALU operation.
- writeSourceSelect  input  1  1 = write selectedInputData, 0 = write ALU result.
- writeEnable  input  1  write-back request.
- conditionalWrite  input  1  write-back only if regfile[aAddress] != 0.
- haltRequest  input  1  unconditional halt.
- haltCondition  input  1  halt if regfile[aAddress] != 0.
- selectedInputData  input  DATA_W  immediate or external switch data from the decoder.
- halt  output  1  sticky halt flag, fed back to the decoder.
- outputData  output  DATA_W  last value written to any register.
- aluResult  output  DATA_W  combinational ALU result (debug).

Behaviour:
Reset:
- rst low at a clk edge clears all registers, halt and outputData to 0.
- Reset has priority over every other event, including mid-halt and simultaneous writes.

Read path and operands:
- Register reads are combinational: opA = muxASelect ? selectedInputData : regfile[aAddress]; opB likewise with muxBSelect and bAddress.

ALU (combinational, result truncated to DATA_W, all values unsigned):
- 0000 pass A.
- 0001 pass B.
- 0010 A+B (carry dropped).
- 0011 -B (two's complement).
- 0100 A&B.
- 0101 A|B.
- 0110 A<<B[3:0].
- 0111 A>>B[3:0] (logical); shift amount >= DATA_W gives 0.
- 1000 (A==B) ? 1 : 0.
- 1001 (A>B) ? 1 : 0.
- Any other opcode gives 0.

Write-back:
- wdata = writeSourceSelect ? selectedInputData : aluResult.
- The write commits at the clk edge iff writeEnable && !halt && (!conditionalWrite || regfile[aAddress] != 0).
- On a commit, outputData <= wdata in the same edge.
- Single-cycle latency: the written value is readable combinationally in the following cycle.
- Reading and writing the same index in one cycle returns the old value (no bypass).

Halt:
- Two states, RUN and HALTED.
- RUN -> HALTED at an edge where haltRequest || (haltCondition && regfile[aAddress] != 0).
- HALTED -> RUN only via reset.
- halt is registered: it asserts the cycle after the halting instruction.
- While HALTED, all writes are suppressed and outputData holds its value.
- A halt request and a write in the same cycle: the write commits (halt not yet set) and halt sets.

Optional Feature:
- Macro: CPU_DATAPATH_FLAGS_EN.
- When defined:
  - Adds outputs zeroFlag (1) and carryFlag (1), reset to 0.
  - Both update only on committed ALU-sourced writes.
  - zeroFlag = (wdata == 0).
  - carryFlag = carry-out of ADD, or the last bit shifted out for SHL/SHR, else 0.
- When undefined: the ports do not exist and no flag logic is built.

Decomposition:
- Shared package cpu_pkg:
  - ALU opcode localparams (ALU_PASS_A … ALU_GT).
  - DATA_W / REG_ADDR_W constants.
  - Same package is used by the decoder.
- One sub-module: alu_unit, purely combinational (opA, opB, aluOpCode -> result, carry).
- Register file, write-back control and halt latch stay in cpu_datapath.

Test Plan:
1. Reset then load: rst=0 for 2 cycles, then writeSourceSelect=1, selectedInputData=0x5A, destAddress=3, writeEnable=1 -> regfile[3]=0x5A and outputData=0x5A the next cycle; halt=0.
2. Add with wrap: r1=0xF0, r2=0x20, aluOpCode=0010, dest=4 -> r4=0x10 (carryFlag=1 when CPU_DATAPATH_FLAGS_EN is defined).
3. Conditional write: r5=0, conditionalWrite=1, aAddress=5 -> dest unchanged. Set r5=1 and repeat -> write commits.
4. Halt: haltCondition=1 with r6=0 -> halt stays 0. With r6=7 -> halt=1 the next cycle; subsequent writeEnable pulses leave registers and outputData unchanged.
5. Shift/compare edge cases:
   - opA=0x81, SHL by 1 -> 0x02.
   - SHR by 9 -> 0x00.
   - EQ 0x33/0x33 -> 0x01.
   - GT 0x01/0x80 -> 0x00.
6. Reset during halt: halted state, rst=0 one cycle -> halt=0, all registers=0, outputData=0.
